// File: rtl/fast_ring_fetch_if.sv
// fast_ring_fetch_if: sram_image read/write port bundle.
//   x_addr  signed AW   pixel x address
//   y_addr  signed BW   pixel y address
//   ren     1           read enable
//   wen     1           write enable
//   rdat    PIXEL_DEPTH read data, valid one cycle after ren
// master = address/enable driver (fetch sequencer), slave = memory.
interface fast_ring_fetch_if #(
    parameter int AW = 4,
    parameter int BW = 4,
    parameter int PIXEL_DEPTH = 8
);
    logic signed [AW-1:0] x_addr;
    logic signed [BW-1:0] y_addr;
    logic ren;
    logic wen;
    logic [PIXEL_DEPTH-1:0] rdat;
    modport master (output x_addr, y_addr, ren, wen, input rdat);
    modport slave (input x_addr, y_addr, ren, wen, output rdat);
endinterface

// File: rtl/fast_ring_fetch.sv
// fast_ring_fetch: reads a centre pixel plus its 16-pixel radius-3 ring from sram_image
// and packs them into one result word for the FAST corner scorer.
//   ramclk, rst              clock, asynchronous active-high reset
//   start_valid/start_ready  centre coordinate handshake (cx, cy unsigned)
//   out_valid/out_ready      result handshake (centre_px, ring slot i at [i*PD +: PD])
//   busy                     sequencer not idle
//   sram                     sram_image port (master side), wen tied low
// Optional build macro FAST_FETCH_OOB_GATE_EN: suppress ren for out-of-image slots.
module fast_ring_fetch #(
    parameter int PIXEL_DEPTH = 8,
    parameter int X_MAX = 5,
    parameter int Y_MAX = 5,
    localparam int AW = $clog2(X_MAX) + 1,
    localparam int BW = $clog2(Y_MAX) + 1
) (
    input  logic ramclk,
    input  logic rst,
    input  logic start_valid,
    output logic start_ready,
    input  logic [AW-1:0] cx,
    input  logic [BW-1:0] cy,
    output logic out_valid,
    input  logic out_ready,
    output logic [PIXEL_DEPTH-1:0] centre_px,
    output logic [16*PIXEL_DEPTH-1:0] ring,
    output logic busy,
    fast_ring_fetch_if.master sram
);
    // Offsets for idx 16 down to idx 0 (3-bit two's complement); idx 0 is the centre.
    localparam logic [16:0][2:0] DX = {3'd7, 3'd6, 3'd5, 3'd5, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1,
                                       3'd2, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    localparam logic [16:0][2:0] DY = {3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3,
                                       3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd5, 3'd0};
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [4:0] idx, cap_idx;
    logic [AW-1:0] cx_q;
    logic [BW-1:0] cy_q;
    logic [AW:0] xw;
    logic [BW:0] yw;
    logic oob, cap_v, cap_oob;
    logic [15:0][PIXEL_DEPTH-1:0] ring_q;
    logic [PIXEL_DEPTH-1:0] cap_dat;

    // One extra bit so cx+dx never wraps; the top bit is the sign.
    assign xw = {1'b0, cx_q} + {{(AW-2){DX[idx][2]}}, DX[idx]};
    assign yw = {1'b0, cy_q} + {{(BW-2){DY[idx][2]}}, DY[idx]};
    assign oob = xw[AW] || xw[AW-1:0] > AW'(X_MAX - 1) || yw[BW] || yw[BW-1:0] > BW'(Y_MAX - 1);
    assign sram.x_addr = state == ISSUE ? xw[AW-1:0] : '0;
    assign sram.y_addr = state == ISSUE ? yw[BW-1:0] : '0;
    assign sram.wen = 1'b0;
`ifdef FAST_FETCH_OOB_GATE_EN
    assign sram.ren = state == ISSUE && !oob;
`else
    assign sram.ren = state == ISSUE;
`endif
    assign start_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign busy = state != IDLE;
    assign ring = ring_q;
    // Zeroing keys off the pipelined flag, never off whatever the memory does with the address.
    assign cap_dat = cap_oob ? '0 : sram.rdat;

    always_comb begin
        state_n = state == IDLE && start_valid ? ISSUE :
                  state == ISSUE && idx == 5'd16 ? DRAIN :
                  state == DRAIN ? DONE :
                  state == DONE && out_ready ? IDLE : state;
    end

    always_ff @(posedge ramclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            cx_q <= '0;
            cy_q <= '0;
            cap_v <= 1'b0;
            cap_oob <= 1'b0;
            cap_idx <= '0;
            centre_px <= '0;
            ring_q <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start_valid) begin
                cx_q <= cx;
                cy_q <= cy;
            end
            if (state == ISSUE) idx <= idx == 5'd16 ? 5'd0 : idx + 5'd1;
            cap_v <= state == ISSUE;
            cap_oob <= oob;
            cap_idx <= idx;
            if (cap_v && cap_idx == 5'd0) centre_px <= cap_dat;
            if (cap_v && cap_idx != 5'd0) ring_q[4'(cap_idx - 5'd1)] <= cap_dat;
        end
    end
endmodule
